// File: rtl/mont_pkg.sv
// Shared constants and state encoding for the Montgomery modular-multiply datapath.
// Reused by the multiplier, the reduction stage and their benches.
package mont_pkg;

    localparam int unsigned WIDTH = 256;
    localparam int unsigned WORD  = 64;
    localparam int unsigned ITER  = WIDTH / WORD;
    localparam int unsigned ACC_W = 2 * WIDTH + 1;
    localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRed,
        StSub
    } state_e;

endpackage

// File: rtl/mont_word_step.sv
// One word-serial Montgomery step: acc_next = (acc + m*N) >> WORD, m = acc_lo * N' mod 2^WORD.
module mont_word_step
    import mont_pkg::*;
(
    input  logic [ACC_W-1:0] acc,
    input  logic [WIDTH-1:0] n,
    input  logic [WORD-1:0]  n_prime,
    output logic [ACC_W-1:0] acc_next
);

    logic [WORD-1:0]       m;
    logic [WIDTH+WORD-1:0] mn;
    logic [ACC_W-1:0]      sum;

    // Truncation to WORD bits is the mod 2^WORD.
    assign m   = acc[WORD-1:0] * n_prime;
    assign mn  = m * n;
    assign sum = acc + ACC_W'(mn);
    // Low WORD bits of sum are zero by choice of m, so the shift is exact.
    assign acc_next = sum >> WORD;

endmodule

// File: rtl/mont_redc.sv
// Word-serial Montgomery reduction Z = P * 2^-WIDTH mod N, one WORD-bit step per clock.
// Define MONT_REDC_FINAL_SUB_EN for a fully reduced Z in [0, N); otherwise Z is lazy, in [0, 2N).
module mont_redc
    import mont_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] P,
    input  logic [WIDTH-1:0]   N,
    input  logic [WORD-1:0]    N_PRIME,
    output logic [WIDTH-1:0]   Z,
    output logic               out_valid
);

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WORD-1:0]  np_q, np_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             ov_q, ov_d;
    logic [ACC_W-1:0] step_acc;

    mont_word_step u_step (
        .acc      (acc_q),
        .n        (n_q),
        .n_prime  (np_q),
        .acc_next (step_acc)
    );

    assign in_ready  = (state_q == StIdle) && !reset;
    assign Z         = z_q;
    assign out_valid = ov_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        n_d     = n_q;
        np_d    = np_q;
        cnt_d   = cnt_q;
        z_d     = z_q;
        ov_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    acc_d   = {1'b0, P};
                    n_d     = N;
                    np_d    = N_PRIME;
                    cnt_d   = '0;
                    state_d = StRed;
                end
            end
            StRed: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
`ifdef MONT_REDC_FINAL_SUB_EN
                    state_d = StSub;
`else
                    state_d = StIdle;
                    z_d     = WIDTH'(step_acc);
                    ov_d    = 1'b1;
`endif
                end
            end
            StSub: begin
                if (acc_q >= ACC_W'(n_q)) begin
                    z_d = WIDTH'(acc_q - ACC_W'(n_q));
                end else begin
                    z_d = WIDTH'(acc_q);
                end
                ov_d    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            acc_q   <= '0;
            n_q     <= '0;
            np_q    <= '0;
            cnt_q   <= '0;
            z_q     <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            n_q     <= n_d;
            np_q    <= np_d;
            cnt_q   <= cnt_d;
            z_q     <= z_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_mont_redc.sv
// Self-checking bench for mont_redc: bit-serial reference model, per-cycle monitor, directed vectors.
// Honours MONT_REDC_FINAL_SUB_EN to select the expected latency and result range.
module tb_mont_redc;

`ifdef MONT_REDC_FINAL_SUB_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] P = '0;
    logic [255:0] N = '0;
    logic [63:0]  N_PRIME = '0;
    logic [255:0] Z;
    logic         out_valid;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [255:0] z;
        logic [255:0] n;
    } exp_t;

    exp_t         expq[$];
    bit           busy = 0;
    int           lat = 0;
    int           n_results = 0;
    logic [255:0] last_z = '0;

    mont_redc dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .P         (P),
        .N         (N),
        .N_PRIME   (N_PRIME),
        .Z         (Z),
        .out_valid (out_valid)
    );

    always #5 clock = ~clock;

    // P * 2^-256 mod n by 256 exact halvings modulo n.
    function automatic logic [255:0] model_redc(input logic [511:0] p, input logic [255:0] n);
        logic [256:0] x;
        x = 257'(p % {256'd0, n});
        for (int i = 0; i < 256; i++) begin
            x = x[0] ? ((x + {1'b0, n}) >> 1) : (x >> 1);
        end
        return x[255:0];
    endfunction

    // -n^-1 mod 2^64 via Newton iteration.
    function automatic logic [63:0] nprime(input logic [255:0] n);
        logic [63:0] inv;
        inv = 64'd1;
        for (int i = 0; i < 7; i++) begin
            inv = inv * (64'd2 - n[63:0] * inv);
        end
        return -inv;
    endfunction

    function automatic logic [255:0] rand256();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: tracks accepted requests and checks every meaningful output cycle.
    always @(negedge clock) begin
        exp_t         e;
        logic [256:0] alt;
        bit           ok;
        if (reset) begin
            expq.delete();
            busy = 0;
            lat  = 0;
        end else begin
            if (busy) lat++;
            if (out_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL out_valid: pulse with no request outstanding, Z=%h", Z);
                end else begin
                    e   = expq.pop_front();
                    alt = {1'b0, e.z} + {1'b0, e.n};
`ifdef MONT_REDC_FINAL_SUB_EN
                    ok = (Z == e.z);
`else
                    ok = (Z == e.z) || ({1'b0, Z} == alt);
`endif
                    if (!ok) begin
                        errors++;
                        $display("FAIL result: got %h expected %h (N=%h)", Z, e.z, e.n);
                    end
                    check("latency", 256'(lat), 256'(LAT));
                    last_z = Z;
                    n_results++;
                end
                busy = 0;
            end else if (busy) begin
                check("in_ready_busy", 256'(in_ready), 256'd0);
            end
            if (in_valid && in_ready) begin
                expq.push_back('{z: model_redc(P, N), n: N});
                busy = 1;
                lat  = 0;
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the accept edge.
    task automatic send(input logic [511:0] p, input logic [255:0] n, output bit ov_at_acc);
        bit got;
        got       = 0;
        ov_at_acc = 0;
        P         = p;
        N         = n;
        N_PRIME   = nprime(n);
        in_valid  = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clock);
            if (in_ready) begin
                got       = 1;
                ov_at_acc = out_valid;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        @(posedge clock);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int target, input int bound);
        for (int i = 0; i < bound && n_results < target; i++) @(negedge clock);
        checks++;
        if (n_results < target) begin
            errors++;
            $display("FAIL result_timeout: got %0d results required %0d", n_results, target);
        end
        @(posedge clock);
        #2;
    endtask

    localparam logic [255:0] N25519 = (256'd1 << 255) - 256'd19;

    initial begin
        bit           ov;
        logic [255:0] n;
        logic [511:0] p;
        int           base;

        // Model pins.
        check("model_zero", model_redc(512'd0, N25519), 256'd0);
        check("model_R", model_redc(512'd1 << 256, N25519), 256'd1);
        check("model_5R", model_redc(512'd5 << 256, N25519), 256'd5);
        check("model_N", model_redc({256'd0, N25519}, N25519), 256'd0);
        check("model_mod3", model_redc(512'd1, 256'd3), 256'd1);
        check("nprime_3", 256'(nprime(256'd3)), 256'h5555555555555555);
        check("nprime_1", 256'(nprime(256'd1)), 256'hffffffffffffffff);
        check("nprime_25519", 256'(64'(N25519[63:0] * nprime(N25519))), 256'hffffffffffffffff);

        // Reset state.
        repeat (2) @(posedge clock);
        #2;
        check("rst_in_ready", 256'(in_ready), 256'd0);
        check("rst_out_valid", 256'(out_valid), 256'd0);
        check("rst_Z", Z, 256'd0);
        reset = 1'b0;
        @(negedge clock);
        check("in_ready_after_rst", 256'(in_ready), 256'd1);
        @(posedge clock);
        #2;

        // Directed vectors.
        send(512'd0, N25519, ov);
        wait_results(1, 50);
        check("P0", last_z, 256'd0);
        send(512'd1 << 256, N25519, ov);
        wait_results(2, 50);
        check("P_R", last_z, 256'd1);
        send({256'd0, N25519}, N25519, ov);
        wait_results(3, 50);
`ifdef MONT_REDC_FINAL_SUB_EN
        check("P_N", last_z, 256'd0);
`else
        check("P_N", last_z, N25519);
`endif
        repeat (3) @(posedge clock);
        #2;
        check("Z_hold", Z, last_z);
        send(512'd1, N25519, ov);
        send(512'd5, 256'd1, ov);
        wait_results(5, 50);
`ifdef MONT_REDC_FINAL_SUB_EN
        check("N1", last_z, 256'd0);
`endif

        // Back-to-back with in_valid held high.
        send(512'd7 << 300, N25519, ov);
        check("b2b_first_idle", 256'(ov), 256'd0);
        send(512'd3 << 256, N25519, ov);
        check("b2b_accept_in_ov_cycle", 256'(ov), 256'd1);
        wait_results(7, 50);
        check("b2b_second", last_z, 256'd3);

        // Reset mid-operation at cnt=2.
        send(512'd9 << 256, N25519, ov);
        @(posedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        @(negedge clock);
        check("abort_Z", Z, 256'd0);
        check("abort_out_valid", 256'(out_valid), 256'd0);
        check("abort_in_ready", 256'(in_ready), 256'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
        @(negedge clock);
        check("abort_in_ready_after", 256'(in_ready), 256'd1);
        repeat (10) @(posedge clock);
        #2;
        check("abort_no_result", 256'(n_results), 256'd7);
        send(512'd11 << 256, N25519, ov);
        wait_results(8, 50);
        check("after_abort", last_z, 256'd11);

        // Random operands.
        base = n_results;
        for (int k = 0; k < 1000; k++) begin
            n      = rand256();
            n[255] = 1'b0;
            n[254] = 1'b1;
            n[0]   = 1'b1;
            p      = {rand256() % n, rand256()};
            send(p, n, ov);
        end
        wait_results(base + 1000, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
